pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 2/3/4-stage pipeline cores. It detects read-after-write hazards between the decode-stage operands and the instructions in Execute and Memory. It generates operand-forwarding selects, counted load-use/RAW stalls, and a counted branch flush with an end-of-flush pulse. It sits beside the decode/execute pipeline registers and drives their stall/flush enables and the operand muxes.

---
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/Execute/Memory hazard-control signal bundle.
// master = pipeline core side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 4
);
    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic              rs1_useD;
    logic              rs2_useD;
    logic [REG_AW-1:0] rdE;
    logic              reg_writeE;
    logic              is_loadE;
    logic [REG_AW-1:0] rdM;
    logic              reg_writeM;
    logic              isBranchTakenE;
    logic              stall;
    logic              flush;
    logic [2:0]        stallC;
    logic              track;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output rs1D, rs2D, rs1_useD, rs2_useD, rdE, reg_writeE, is_loadE,
               rdM, reg_writeM, isBranchTakenE,
        input  stall, flush, stallC, track, fwd_a, fwd_b
    );

    modport slave (
        input  rs1D, rs2D, rs1_useD, rs2_useD, rdE, reg_writeE, is_loadE,
               rdM, reg_writeM, isBranchTakenE,
        output stall, flush, stallC, track, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard controller: forwarding selects, counted stalls, counted branch flush.
// Define HAZARD_FORWARD_EN to enable operand forwarding (load-use stalls only).
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LOAD_LAT     = 1
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave hz
);
    logic [REG_AW-1:0] rs1, rs2, rde, rdm;
    logic              e1, e2, m1, m2;
    logic              hazard;
    logic [1:0]        haz_len;
    logic [2:0]        flush_cnt, flush_cnt_n;
    logic [1:0]        stall_cnt, stall_cnt_n;
    logic              track_q, track_n;

    assign rs1 = hz.rs1D;
    assign rs2 = hz.rs2D;
    assign rde = hz.rdE;
    assign rdm = hz.rdM;

    // Register 0 is hardwired zero, so it never matches a writer.
    assign e1 = hz.reg_writeE && (rde != '0) && hz.rs1_useD && (rs1 == rde);
    assign e2 = hz.reg_writeE && (rde != '0) && hz.rs2_useD && (rs2 == rde);
    assign m1 = hz.reg_writeM && (rdm != '0) && hz.rs1_useD && (rs1 == rdm);
    assign m2 = hz.reg_writeM && (rdm != '0) && hz.rs2_useD && (rs2 == rdm);

`ifdef HAZARD_FORWARD_EN
    // A load in E has no result yet, so it falls through to the M match.
    assign hz.fwd_a = (e1 && !hz.is_loadE) ? 2'b01 : (m1 ? 2'b10 : 2'b00);
    assign hz.fwd_b = (e2 && !hz.is_loadE) ? 2'b01 : (m2 ? 2'b10 : 2'b00);
    assign hazard   = (e1 || e2) && hz.is_loadE;
    assign haz_len  = 2'(LOAD_LAT);
`else
    logic unused_cfg;
    assign unused_cfg = ^{hz.is_loadE, 2'(LOAD_LAT)};
    assign hz.fwd_a   = 2'b00;
    assign hz.fwd_b   = 2'b00;
    assign hazard     = e1 || e2 || m1 || m2;
    assign haz_len    = (e1 || e2) ? 2'd2 : 2'd1;
`endif

    always_comb begin
        track_n     = 1'b0;
        flush_cnt_n = flush_cnt;
        stall_cnt_n = stall_cnt;
        if (flush_cnt != '0) begin
            flush_cnt_n = flush_cnt - 3'd1;
            track_n     = (flush_cnt == 3'd1);
            stall_cnt_n = '0;
        end else if (hz.isBranchTakenE) begin
            flush_cnt_n = 3'(FLUSH_CYCLES);
            stall_cnt_n = '0;
        end else if (stall_cnt != '0) begin
            stall_cnt_n = stall_cnt - 2'd1;
        end else if (hazard) begin
            stall_cnt_n = haz_len;
        end else begin
            stall_cnt_n = '0;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
            track_q   <= 1'b0;
        end else begin
            flush_cnt <= flush_cnt_n;
            stall_cnt <= stall_cnt_n;
            track_q   <= track_n;
        end
    end

    assign hz.stall  = (stall_cnt != '0);
    assign hz.flush  = (flush_cnt != '0);
    assign hz.stallC = flush_cnt;
    assign hz.track  = track_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl; expectations follow HAZARD_FORWARD_EN.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned FC     = 2;
    localparam int unsigned LL     = 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b1;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

    pipeline_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .FLUSH_CYCLES(FC),
        .LOAD_LAT    (LL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rs1, rs2;
        logic       u1, u2;
        logic [3:0] rde;
        logic       we, ld;
        logic [3:0] rdm;
        logic       wm;
        logic [1:0] fa, fb;
    } fvec_t;

    typedef struct {
        logic       stall, flush;
        logic [2:0] sc;
        logic       track;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1,
                          input logic u2, input logic [3:0] rde, input logic we,
                          input logic ld, input logic [3:0] rdm, input logic wm,
                          input logic br);
        hz.rs1D = rs1; hz.rs2D = rs2; hz.rs1_useD = u1; hz.rs2_useD = u2;
        hz.rdE = rde; hz.reg_writeE = we; hz.is_loadE = ld;
        hz.rdM = rdm; hz.reg_writeM = wm; hz.isBranchTakenE = br;
    endtask

    task automatic idle();
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Push the expected post-edge state, clock one falling edge, pop and compare.
    task automatic tick(input logic es, input logic ef, input logic [2:0] esc, input logic et);
        exp_t e;
        e.stall = es; e.flush = ef; e.sc = esc; e.track = et;
        sb.push_back(e);
        @(negedge clk);
        #1;
        e = sb.pop_front();
        check("stall", 8'(hz.stall), 8'(e.stall));
        check("flush", 8'(hz.flush), 8'(e.flush));
        check("stallC", 8'(hz.stallC), 8'(e.sc));
        check("track", 8'(hz.track), 8'(e.track));
    endtask

    // Hazard inputs stay applied for the whole stall and one edge beyond it.
    task automatic run_hazard(input int unsigned len);
        for (int unsigned k = 0; k < len; k++) tick(1'b1, 1'b0, 3'd0, 1'b0);
        tick(1'b0, 1'b0, 3'd0, 1'b0);
        idle();
        tick(1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic flush_tail();
        for (int unsigned k = 1; k <= FC; k++)
            tick(1'b0, (FC - k) != 0, 3'(FC - k), (FC - k) == 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fvec_t tbl[8];
        tbl[0] = '{4'd3, 4'd0, 1, 0, 4'd3, 1, 0, 4'd3, 1, 2'b01, 2'b00};
        tbl[1] = '{4'd3, 4'd0, 1, 0, 4'd5, 1, 0, 4'd3, 1, 2'b10, 2'b00};
        tbl[2] = '{4'd7, 4'd7, 1, 1, 4'd7, 1, 0, 4'd0, 0, 2'b01, 2'b01};
        tbl[3] = '{4'd0, 4'd0, 1, 1, 4'd0, 1, 0, 4'd0, 1, 2'b00, 2'b00};
        tbl[4] = '{4'd6, 4'd0, 1, 0, 4'd6, 1, 1, 4'd6, 1, 2'b10, 2'b00};
        tbl[5] = '{4'd9, 4'd9, 0, 1, 4'd9, 1, 0, 4'd0, 0, 2'b00, 2'b01};
        tbl[6] = '{4'd4, 4'd4, 1, 1, 4'd4, 0, 0, 4'd4, 0, 2'b00, 2'b00};
        tbl[7] = '{4'd1, 4'd12, 1, 1, 4'd12, 0, 0, 4'd12, 1, 2'b00, 2'b10};

        reset = 1'b0;
        idle();
        #1;
        check("reset_stall", 8'(hz.stall), 8'd0);
        check("reset_flush", 8'(hz.flush), 8'd0);
        check("reset_stallC", 8'(hz.stallC), 8'd0);
        check("reset_track", 8'(hz.track), 8'd0);
        @(posedge clk);
        @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;

        // Combinational forwarding: applied and removed within one high phase.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rde,
                   tbl[i].we, tbl[i].ld, tbl[i].rdm, tbl[i].wm, 1'b0);
            #1;
            check($sformatf("fwd_a[%0d]", i), 8'(hz.fwd_a), FWD ? 8'(tbl[i].fa) : 8'd0);
            check($sformatf("fwd_b[%0d]", i), 8'(hz.fwd_b), FWD ? 8'(tbl[i].fb) : 8'd0);
            idle();
        end
        @(negedge clk);
        #1;

        // Load-use on rs2.
        set_in(4'd0, 4'd4, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        run_hazard(FWD ? LL : 2);
        // Load to register 0 never hazards.
        set_in(4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        run_hazard(0);
        // Non-load E match.
        set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        run_hazard(FWD ? 0 : 2);
        // M match only.
        set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        run_hazard(FWD ? 0 : 1);
        // Operand not read.
        set_in(4'd2, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
        run_hazard(0);

        // Branch held high across the flush: later branches are ignored.
        idle();
        hz.isBranchTakenE = 1'b1;
        tick(1'b0, 1'b1, 3'(FC), 1'b0);
        flush_tail();
        idle();
        tick(1'b0, 1'b0, 3'd0, 1'b0);

        // Branch and load-use together; hazard held through the flush.
        set_in(4'd0, 4'd4, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 3'(FC), 1'b0);
        hz.isBranchTakenE = 1'b0;
        flush_tail();
        idle();
        tick(1'b0, 1'b0, 3'd0, 1'b0);

        // Branch abandons a stall already in progress.
        set_in(4'd0, 4'd4, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 3'd0, 1'b0);
        hz.isBranchTakenE = 1'b1;
        tick(1'b0, 1'b1, 3'(FC), 1'b0);
        idle();
        flush_tail();
        tick(1'b0, 1'b0, 3'd0, 1'b0);

        // Reset between edges with stallC=1: immediate clear, no track later.
        hz.isBranchTakenE = 1'b1;
        tick(1'b0, 1'b1, 3'(FC), 1'b0);
        idle();
        for (int unsigned k = 1; k < FC; k++) tick(1'b0, 1'b1, 3'(FC - k), 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("async_stall", 8'(hz.stall), 8'd0);
        check("async_flush", 8'(hz.flush), 8'd0);
        check("async_stallC", 8'(hz.stallC), 8'd0);
        check("async_track", 8'(hz.track), 8'd0);
        #1;
        reset = 1'b1;
        tick(1'b0, 1'b0, 3'd0, 1'b0);
        tick(1'b0, 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
